// File: rtl/serializador_if.sv
// serializador_if: queue-head side and serial-link side of the word serializer.
interface serializador_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] word_in;
    logic             word_valid;
    logic             dequeue_out;
    logic             status_in;
    logic             data_out;
    logic             write_out;
    logic             busy_out;
    logic [7:0]       frames_sent;
    modport master(input word_in, word_valid, status_in,
                   output dequeue_out, data_out, write_out, busy_out, frames_sent);
    modport slave(output word_in, word_valid, status_in,
                  input dequeue_out, data_out, write_out, busy_out, frames_sent);
endinterface

// File: rtl/serializador.sv
// serializador: pops words from a FWFT queue and shifts them out one bit per ready strobe.
module serializador #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 1
) (
    input logic             clk_100KHz,
    input logic             reset,
    serializador_if.master  bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       gap_cnt;
    // gated by reset so no pop leaks out while the block is held in reset
    assign bus.dequeue_out = reset && state == IDLE && bus.word_valid;
    always_ff @(posedge clk_100KHz) begin
        if (!reset) begin
            state           <= IDLE;
            sh              <= '0;
            bit_cnt         <= '0;
            gap_cnt         <= '0;
            bus.data_out    <= 1'b0;
            bus.write_out   <= 1'b0;
            bus.busy_out    <= 1'b0;
            bus.frames_sent <= '0;
        end else begin
            bus.write_out <= 1'b0;
            case (state)
                IDLE: if (bus.word_valid) begin
                    sh           <= bus.word_in;
                    bit_cnt      <= '0;
                    bus.busy_out <= 1'b1;
                    state        <= SEND;
                end
                SEND: if (bus.status_in) begin
                    bus.data_out  <= MSB_FIRST ? sh[WIDTH-1] : sh[0];
                    bus.write_out <= 1'b1;
                    sh            <= MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
                    bit_cnt       <= bit_cnt + 1'b1;
                    if (bit_cnt == CW'(WIDTH - 1)) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
                    bus.frames_sent <= bus.frames_sent + 8'd1;
                    bus.busy_out    <= 1'b0;
                    state           <= IDLE;
                end else begin
                    gap_cnt <= gap_cnt + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serializador.sv
// tb_serializador: directed checks of the serializer, MSB-first and LSB-first builds.
module tb_serializador;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] w;

    always #5 clk = ~clk;

    serializador_if #(.WIDTH(8)) bus_a();
    serializador_if #(.WIDTH(8)) bus_b();

    serializador #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(1)) dut_a (
        .clk_100KHz(clk), .reset(reset), .bus(bus_a));
    serializador #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(1)) dut_b (
        .clk_100KHz(clk), .reset(reset), .bus(bus_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    // sends remaining MSB-first bits of w on dut_a, from bit index 'from' onward
    task automatic bits_a(input string tag, input int from);
        for (int i = from; i < 8; i++) begin
            step;
            check(tag, {30'd0, bus_a.write_out, bus_a.data_out}, {30'd0, 1'b1, w[7-i]});
            check({tag, "_nopop"}, {31'd0, bus_a.dequeue_out}, 32'd0);
        end
    endtask

    initial begin
        bus_a.word_in = 8'hA5; bus_a.word_valid = 1'b1; bus_a.status_in = 1'b1;
        bus_b.word_in = 8'h01; bus_b.word_valid = 1'b0; bus_b.status_in = 1'b1;
        // reset held with a word waiting
        for (int i = 0; i < 3; i++) begin
            step;
            check("rst_outs", {27'd0, bus_a.data_out, bus_a.write_out, bus_a.busy_out,
                               bus_a.dequeue_out, 1'b0}, 32'd0);
            check("rst_frames", {24'd0, bus_a.frames_sent}, 32'd0);
        end
        reset = 1'b1;
        #1 check("rel_pop", {31'd0, bus_a.dequeue_out}, 32'd1);
        // 0xA5 straight through
        w = 8'hA5;
        step;
        bus_a.word_valid = 1'b0;
        #1 check("load_busy", {30'd0, bus_a.busy_out, bus_a.write_out}, 32'd2);
        check("load_pop", {31'd0, bus_a.dequeue_out}, 32'd0);
        bits_a("a5_bit", 0);
        step;
        check("a5_gap", {30'd0, bus_a.write_out, bus_a.busy_out}, 32'd0);
        check("a5_frames", {24'd0, bus_a.frames_sent}, 32'd1);
        // 0xA5 with a 4-cycle stall after the third bit
        bus_a.word_valid = 1'b1;
        #1 check("st_pop", {31'd0, bus_a.dequeue_out}, 32'd1);
        step;
        bus_a.word_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            check("st_bit", {30'd0, bus_a.write_out, bus_a.data_out}, {30'd0, 1'b1, w[7-i]});
        end
        bus_a.status_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step;
            check("st_hold", {30'd0, bus_a.write_out, bus_a.data_out}, 32'd1);
        end
        bus_a.status_in = 1'b1;
        bits_a("st_resume", 3);
        step;
        check("st_frames", {24'd0, bus_a.frames_sent}, 32'd2);
        // back-to-back 0x3C then 0xFF
        w = 8'h3C;
        bus_a.word_in = 8'h3C; bus_a.word_valid = 1'b1;
        #1 check("bb_pop1", {31'd0, bus_a.dequeue_out}, 32'd1);
        step;
        bus_a.word_in = 8'hFF;
        bits_a("bb_3c", 0);
        step;
        check("bb_pop2", {31'd0, bus_a.dequeue_out}, 32'd1);
        check("bb_frames1", {24'd0, bus_a.frames_sent}, 32'd3);
        w = 8'hFF;
        step;
        bus_a.word_valid = 1'b0;
        bits_a("bb_ff", 0);
        step;
        check("bb_frames2", {24'd0, bus_a.frames_sent}, 32'd4);
        // reset after the fifth bit of 0xC3
        w = 8'hC3;
        bus_a.word_in = 8'hC3; bus_a.word_valid = 1'b1;
        step;
        bus_a.word_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step;
            check("ab_bit", {30'd0, bus_a.write_out, bus_a.data_out}, {30'd0, 1'b1, w[7-i]});
        end
        reset = 1'b0;
        step;
        check("ab_quiet", {30'd0, bus_a.write_out, bus_a.busy_out}, 32'd0);
        check("ab_frames", {24'd0, bus_a.frames_sent}, 32'd0);
        reset = 1'b1;
        w = 8'h80;
        bus_a.word_in = 8'h80; bus_a.word_valid = 1'b1;
        #1 check("ab_pop", {31'd0, bus_a.dequeue_out}, 32'd1);
        step;
        bus_a.word_valid = 1'b0;
        bits_a("ab_next", 0);
        step;
        check("ab_frames2", {24'd0, bus_a.frames_sent}, 32'd1);
        // LSB-first build: 0x01 repeated 256 times, counter wraps
        for (int f = 0; f < 256; f++) begin
            bus_b.word_valid = 1'b1;
            #1 if (f == 0) check("lsb_pop", {31'd0, bus_b.dequeue_out}, 32'd1);
            step;
            bus_b.word_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                step;
                if (f == 0)
                    check("lsb_bit", {30'd0, bus_b.write_out, bus_b.data_out},
                          {30'd0, 1'b1, i == 0});
            end
            step;
            if (f == 0) check("lsb_frames1", {24'd0, bus_b.frames_sent}, 32'd1);
            if (f == 254) check("lsb_frames255", {24'd0, bus_b.frames_sent}, 32'd255);
        end
        check("lsb_wrap", {24'd0, bus_b.frames_sent}, 32'd0);
        check("lsb_idle", {30'd0, bus_b.busy_out, bus_b.dequeue_out}, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
